// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard using the request-to-send sequence.
// The sequence is: inhibit the clock, assert the start bit, release the clock, then shift the
// data out on device clock falls and check for the device ACK.
//
// Ports:
//   clk, reset         system clock and synchronous active-high reset
//   start, data        1-cycle request strobe and the byte to send (sampled with start)
//   busy, rx_inhibit   transaction in progress, including the done/err cycle
//   done, err          1-cycle completion pulses (ACK received / missing ACK or timeout)
//   ps2c_in, ps2d_in   raw asynchronous PS/2 pads
//   ps2c_oe, ps2d_oe   open-drain enables; 1 pulls the line low
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rx_inhibit,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StSend, StAck, StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [8:0]      shift_q, shift_d;
  logic            d_oe_q, d_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            c_meta_q, c_sync_q, c_prev_q;
  logic            d_meta_q, d_sync_q;
  logic            fall;
  logic            start_ok;

  // Synchronisers idle high so leaving reset never produces a false clock fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      c_prev_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      c_meta_q <= ps2c_in;
      c_sync_q <= c_meta_q;
      c_prev_q <= c_sync_q;
      d_meta_q <= ps2d_in;
      d_sync_q <= d_meta_q;
    end
  end

  assign fall     = c_prev_q & ~c_sync_q;
  assign busy     = (state_q != StIdle) | done_q | err_q;
  assign start_ok = start & ~busy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    d_oe_d   = d_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StInhibit;
          cnt_d   = '0;
          shift_d = {~^data, data};
          d_oe_d  = 1'b0;
        end
      end
      StInhibit: begin
        if (cnt_q == InhLast) begin
          state_d = StReq;
          d_oe_d  = 1'b1;  // start bit, held until the first device fall
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        state_d  = StSend;
        cnt_d    = '0;
        bitcnt_d = '0;
      end
      StSend, StAck, StWaitIdle: begin
        cnt_d = fall ? '0 : cnt_q + 1'b1;
        // A timeout wins over a fall arriving in the same cycle.
        if (cnt_q >= TmoLast) begin
          state_d = StIdle;
          d_oe_d  = 1'b0;
          err_d   = 1'b1;
        end else if (state_q == StSend) begin
          if (fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              d_oe_d  = 1'b0;  // stop bit: release data
              state_d = StAck;
            end else begin
              d_oe_d = ~shift_q[bitcnt_q];
            end
          end
        end else if (state_q == StAck) begin
          if (fall) begin
            if (!d_sync_q) begin
              state_d = StWaitIdle;
            end else begin
              state_d = StIdle;
              err_d   = 1'b1;
            end
          end
        end else begin
          if (c_sync_q && d_sync_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        d_oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      d_oe_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      d_oe_q   <= d_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign rx_inhibit = busy;
  assign ps2c_oe    = (state_q == StInhibit) || (state_q == StReq);
  assign ps2d_oe    = d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames and records the line bits.
// The stimulus pushes the expected outcome and frame for each command, and a monitor pops and
// compares these on every done/err pulse.
module tb_ps2_host_tx;

  localparam int unsigned InhCycles = 2500;
  localparam int unsigned TmoCycles = 1000;
  localparam int unsigned Half      = 50;   // device clock half period in clk cycles
  localparam int unsigned Budget    = 6000;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] data;
  logic       busy, done, err, rx_inhibit;
  logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;

  // Open-drain lines with pull-ups: low if either side pulls.
  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhCycles),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rx_inhibit(rx_inhibit),
    .ps2c_in   (ps2c_in),
    .ps2d_in   (ps2d_in),
    .ps2c_oe   (ps2c_oe),
    .ps2d_oe   (ps2d_oe)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic        chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_q[$];

  int dev_mode = 0;  // 0: ACK, 1: no ACK, 2: stall after stall_at falls
  int stall_at = 0;
  int fall_cnt = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line order: start(0), d0..d7, parity, stop(1).
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic push_exp(input logic is_err, input logic chk, input logic [10:0] fr);
    exp_t e;
    e.is_err    = is_err;
    e.chk_frame = chk;
    e.frame     = fr;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    data  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    @(negedge clk);
    while (!(done || err) && n < Budget) begin
      n++;
      @(negedge clk);
    end
    if (n >= Budget) begin
      checks++;
      errors++;
      $display("FAIL %s_end: no done/err within %0d cycles", name, Budget);
    end else begin
      @(negedge clk);
      check({name, "_idle_after"}, {busy, rx_inhibit, done, err}, 4'b0000);
    end
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (fall_cnt != target && n < Budget) begin
      n++;
      @(negedge clk);
    end
    if (n >= Budget) begin
      checks++;
      errors++;
      $display("FAIL wait_falls: got %0d falls, expected %0d", fall_cnt, target);
    end
  endtask

  // Device model: answers each request, samples the data line before every fall.
  initial begin : device
    logic [10:0] fr;
    forever begin
      @(posedge clk);
      if (ps2c_oe && ps2d_oe) begin
        for (int k = 0; k < 4 && ps2c_oe; k++) @(posedge clk);
        fall_cnt = 0;
        repeat (Half) @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
          fr[i] = ps2d_in;
          if (i == 10) begin
            obs_q.push_back(fr);
            if (dev_mode == 0) begin
              dev_d = 1'b0;
              repeat (5) @(posedge clk);
              #1;
            end
          end
          dev_c    = 1'b0;
          fall_cnt = fall_cnt + 1;
          fall_cyc = cyc;
          repeat (Half) @(posedge clk);
          #1;
          dev_c = 1'b1;
          if (dev_mode == 2 && fall_cnt == stall_at) break;
          repeat (Half) @(posedge clk);
          #1;
        end
        dev_d = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || err) begin
        check("busy_at_pulse", {busy, rx_inhibit}, 2'b11);
        check("lines_released", {ps2c_oe, ps2d_oe}, 2'b00);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b, none pending", done, err);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done_err", {done, err}, e.is_err ? 2'b01 : 2'b10);
          if (e.chk_frame) begin
            if (obs_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_missing: got none, expected %0h", e.frame);
            end else begin
              check("frame", obs_q.pop_front(), e.frame);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int t0;
    int dt;
    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {busy, done, err, rx_inhibit, ps2c_oe, ps2d_oe}, 6'b0);

    // 0xED: request timing, then a full ACKed frame (parity 1: six ones).
    push_exp(1'b0, 1'b1, mk_frame(8'hED, 1'b1));
    dev_mode = 0;
    do_start(8'hED);
    @(negedge clk);
    check("busy_after_start", {busy, rx_inhibit}, 2'b11);
    n = 0;
    while (ps2c_oe && !ps2d_oe && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, InhCycles);
    check("req_both_oe", {ps2c_oe, ps2d_oe}, 2'b11);
    @(negedge clk);
    check("clock_released_start_bit", {ps2c_oe, ps2d_oe}, 2'b01);
    wait_end("ed");
    repeat (200) @(posedge clk);

    // 0x01 with no ACK: parity 0 sent, err pulse.
    push_exp(1'b1, 1'b1, mk_frame(8'h01, 1'b0));
    dev_mode = 1;
    do_start(8'h01);
    wait_end("noack");
    repeat (200) @(posedge clk);

    // 0x55, device stalls after fall 4 (d3=0 so data is pulled low meanwhile).
    push_exp(1'b1, 1'b0, 11'h0);
    dev_mode = 2;
    stall_at = 4;
    do_start(8'h55);
    wait_falls(4);
    t0 = fall_cyc;
    repeat (10) @(negedge clk);
    check("stall_data_pulled", ps2d_oe, 1'b1);
    n = 0;
    while (!err && n < int'(TmoCycles) + 100) begin
      n++;
      @(negedge clk);
    end
    // The fall is seen 3 cycles after the pad edge; err follows TmoCycles (+0/+1) later.
    dt = cyc - t0;
    checks++;
    if (!(dt == int'(TmoCycles) + 3 || dt == int'(TmoCycles) + 4)) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, expected %0d or %0d", dt,
               TmoCycles + 3, TmoCycles + 4);
    end
    @(negedge clk);
    check("timeout_idle_after", {busy, err, ps2c_oe, ps2d_oe}, 4'b0);
    repeat (200) @(posedge clk);

    // 0xF4 (five ones: parity 0) with a 0xFF start issued mid-frame, which must be ignored.
    push_exp(1'b0, 1'b1, mk_frame(8'hF4, 1'b0));
    dev_mode = 0;
    do_start(8'hF4);
    repeat (2800) @(posedge clk);
    check("busy_mid_frame", busy, 1'b1);
    do_start(8'hFF);
    wait_end("f4");
    repeat (300) @(posedge clk);
    check("no_second_frame", {busy, ps2c_oe}, 2'b00);

    // Reset mid-SEND while data is pulled low, then a clean 0x12 frame (parity 1).
    dev_mode = 2;
    stall_at = 2;
    do_start(8'h00);
    wait_falls(2);
    repeat (10) @(negedge clk);
    check("send_data_pulled", ps2d_oe, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_frame", {busy, done, err, rx_inhibit, ps2c_oe, ps2d_oe}, 6'b0);
    repeat (200) @(posedge clk);
    push_exp(1'b0, 1'b1, mk_frame(8'h12, 1'b1));
    dev_mode = 0;
    do_start(8'h12);
    wait_end("post_reset");
    repeat (200) @(posedge clk);

    check("exp_drained", exp_q.size(), 0);
    check("obs_drained", obs_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
